// File: rtl/serial_adder_fsm_if.sv
// Request/result bundle for the bit-serial adder.
// The requester (master) drives the operands and start strobe; the adder
// (slave) returns its status flags and the registered result.
interface serial_adder_fsm_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder.
// One full-adder cell, built from two half adders, is reused for WIDTH
// cycles. Operand bits enter LSB-first and the carry-out is registered as
// the next cycle's carry-in. Sum bits collect MSB-first in a shift register,
// so after WIDTH shifts the register already holds the parallel result.
// That result then goes to the output register together with a one-cycle
// done pulse.
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_adder_fsm_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_p;
  logic fa_g1;
  logic fa_s;
  logic fa_g2;
  logic fa_co;

  // One-bit full adder made of two half adders, fed by the operand LSBs and the carry flop
  always_comb begin
    fa_p  = a_sr_q[0] ^ b_sr_q[0];
    fa_g1 = a_sr_q[0] & b_sr_q[0];
    fa_s  = fa_p ^ carry_q;
    fa_g2 = fa_p & carry_q;
    fa_co = fa_g1 | fa_g2;
  end

  // Next-state and datapath control: load in IDLE, shift one bit per RUN cycle, publish on the last bit
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_sr_d  = {fa_s, s_sr_q[WIDTH-1:1]};
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = {fa_s, s_sr_q[WIDTH-1:1]};
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any add and clears the published result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Status flags are pure decodes of the state register, so they never depend on inputs
  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
    bus.sum  = sum_q;
    bus.cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Testbench for serial_adder_fsm.
// It drives an 8-bit and a 16-bit instance. Expected results come from
// plain integer addition of the operands.
module tb_serial_adder_fsm;

  logic clk;
  logic rst;

  int checks;
  int failures;

  serial_adder_fsm_if #(.WIDTH(8))  bus8 ();
  serial_adder_fsm_if #(.WIDTH(16)) bus16 ();

  serial_adder_fsm #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_adder_fsm #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  // Free-running clock: rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Run one 8-bit add and measure it. After the accepting edge the operands
  // are scrambled. The latency is counted in negedges after E0 and is 0 on
  // timeout. pre_s/pre_co hold the outputs on the last busy cycle.
  task automatic run_add8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          output int lat, output int busy_n,
                          output logic [7:0] s, output logic co,
                          output logic [7:0] pre_s, output logic pre_co);
    lat    = 0;
    busy_n = 0;
    s      = '0;
    co     = 1'b0;
    pre_s  = '0;
    pre_co = 1'b0;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = av;
    bus8.b     = bv;
    bus8.cin   = cv;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.cin   = 1'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus8.busy) begin
        busy_n++;
        pre_s  = bus8.sum;
        pre_co = bus8.cout;
      end
      if (bus8.done) begin
        lat = k;
        s   = bus8.sum;
        co  = bus8.cout;
        break;
      end
    end
  endtask

  // Same as run_add8 for the 16-bit instance
  task automatic run_add16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                           output int lat, output logic [15:0] s, output logic co);
    lat = 0;
    s   = '0;
    co  = 1'b0;
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.a     = av;
    bus16.b     = bv;
    bus16.cin   = cv;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    bus16.a     = 16'($urandom);
    bus16.b     = 16'($urandom);
    bus16.cin   = 1'($urandom);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus16.done) begin
        lat = k;
        s   = bus16.sum;
        co  = bus16.cout;
        break;
      end
    end
  endtask

  // Reset asserted mid-cycle clears outputs at once, then an all-zero add
  task automatic test_reset();
    int lat, busy_n;
    logic [7:0] s, pre_s;
    logic co, pre_co;
    rst = 1'b0;
    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.cout} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs8: busy=%b done=%b sum=%h cout=%b, required all 0",
               bus8.busy, bus8.done, bus8.sum, bus8.cout);
    end
    checks++;
    if ({bus16.busy, bus16.done, bus16.sum, bus16.cout} !== 19'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs16: busy=%b done=%b sum=%h cout=%b, required all 0",
               bus16.busy, bus16.done, bus16.sum, bus16.cout);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_add8(8'h00, 8'h00, 1'b0, lat, busy_n, s, co, pre_s, pre_co);
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("[TB] FAIL zero_add_latency: got %0d, required 9", lat);
    end
    checks++;
    if ({co, s} !== 9'h000) begin
      failures++;
      $display("[TB] FAIL zero_add_result: got cout=%b sum=%h, required cout=0 sum=00", co, s);
    end
  endtask

  // Overflow case and exact busy/done pulse widths
  task automatic test_overflow_timing();
    int lat, busy_n;
    logic [7:0] s, pre_s;
    logic co, pre_co;
    run_add8(8'hFF, 8'h01, 1'b0, lat, busy_n, s, co, pre_s, pre_co);
    checks++;
    if ({co, s} !== 9'h100) begin
      failures++;
      $display("[TB] FAIL ff_plus_1: got cout=%b sum=%h, required cout=1 sum=00", co, s);
    end
    checks++;
    if (busy_n !== 8) begin
      failures++;
      $display("[TB] FAIL busy_width: got %0d cycles, required 8", busy_n);
    end
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("[TB] FAIL done_latency: got %0d, required 9", lat);
    end
    @(negedge clk);
    checks++;
    if ({bus8.busy, bus8.done} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL done_width: after done got busy=%b done=%b, required 0 0",
               bus8.busy, bus8.done);
    end
  endtask

  // Carry-in path, and result holding through the following add
  task automatic test_hold_between_adds();
    int lat, busy_n;
    logic [7:0] s, pre_s;
    logic co, pre_co;
    run_add8(8'hA5, 8'h5A, 1'b1, lat, busy_n, s, co, pre_s, pre_co);
    checks++;
    if ({co, s} !== 9'h100) begin
      failures++;
      $display("[TB] FAIL a5_5a_cin: got cout=%b sum=%h, required cout=1 sum=00", co, s);
    end
    run_add8(8'h3C, 8'h42, 1'b0, lat, busy_n, s, co, pre_s, pre_co);
    checks++;
    if ({pre_co, pre_s} !== 9'h100) begin
      failures++;
      $display("[TB] FAIL hold_during_run: got cout=%b sum=%h, required cout=1 sum=00",
               pre_co, pre_s);
    end
    checks++;
    if ({co, s} !== 9'h07E) begin
      failures++;
      $display("[TB] FAIL 3c_42: got cout=%b sum=%h, required cout=0 sum=7e", co, s);
    end
  endtask

  // Start pulses during RUN are ignored; a start held through DONE is taken on the first IDLE edge
  task automatic test_start_ignored();
    int lat;
    logic [7:0] s;
    logic co;
    lat = 0;
    s   = '0;
    co  = 1'b0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus8.done) begin
        lat = k;
        s   = bus8.sum;
        co  = bus8.cout;
        bus8.start = 1'b1; bus8.a = 8'h0F; bus8.b = 8'h01; bus8.cin = 1'b1;
        break;
      end
      if (k == 3 || k == 8) begin
        bus8.start = 1'b1;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        bus8.cin   = 1'($urandom);
      end else begin
        bus8.start = 1'b0;
      end
    end
    checks++;
    if (lat !== 9 || {co, s} !== 9'h046) begin
      failures++;
      $display("[TB] FAIL ignore_start_result: got lat=%0d cout=%b sum=%h, required lat=9 cout=0 sum=46",
               lat, co, s);
    end
    @(negedge clk);
    checks++;
    if ({bus8.busy, bus8.done} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL idle_after_done: got busy=%b done=%b, required 0 0", bus8.busy, bus8.done);
    end
    @(negedge clk);
    checks++;
    if (bus8.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL held_start_accept: got busy=%b, required 1", bus8.busy);
    end
    bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus8.done) begin
        lat = k;
        s   = bus8.sum;
        co  = bus8.cout;
        break;
      end
    end
    checks++;
    if (lat == 0 || {co, s} !== 9'h011) begin
      failures++;
      $display("[TB] FAIL held_start_result: got lat=%0d cout=%b sum=%h, required cout=0 sum=11",
               lat, co, s);
    end
  endtask

  // Reset during RUN aborts the add with no done and a cleared result
  task automatic test_reset_mid_run();
    int lat, busy_n, done_seen;
    logic [7:0] s, pre_s;
    logic co, pre_co;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h7F; bus8.b = 8'h01; bus8.cin = 1'b0;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.cout} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b, required all 0",
               bus8.busy, bus8.done, bus8.sum, bus8.cout);
    end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("[TB] FAIL no_done_after_abort: got %0d active cycles, required 0", done_seen);
    end
    run_add8(8'h7F, 8'h01, 1'b0, lat, busy_n, s, co, pre_s, pre_co);
    checks++;
    if ({co, s} !== 9'h080 || lat !== 9) begin
      failures++;
      $display("[TB] FAIL after_abort_add: got lat=%0d cout=%b sum=%h, required lat=9 cout=0 sum=80",
               lat, co, s);
    end
  endtask

  // Back-to-back random adds on both widths against integer addition
  task automatic test_random();
    int lat, busy_n;
    logic [7:0] s8, pre_s;
    logic [15:0] s16;
    logic co, pre_co;
    logic [7:0] a8, b8;
    logic [15:0] a16, b16;
    logic c;
    int unsigned expect_v;
    for (int n = 0; n < 1000; n++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c = 1'($urandom);
      if (n == 0) begin a8 = 8'hFF; b8 = 8'hFF; c = 1'b1; end
      expect_v = 32'(a8) + 32'(b8) + 32'(c);
      run_add8(a8, b8, c, lat, busy_n, s8, co, pre_s, pre_co);
      checks++;
      if (lat !== 9 || {co, s8} !== expect_v[8:0]) begin
        failures++;
        $display("[TB] FAIL rand8 #%0d: a=%h b=%h cin=%b got lat=%0d {cout,sum}=%h, required lat=9 %h",
                 n, a8, b8, c, lat, {co, s8}, expect_v[8:0]);
      end
    end
    for (int n = 0; n < 1000; n++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); c = 1'($urandom);
      if (n == 0) begin a16 = 16'hFFFF; b16 = 16'h0000; c = 1'b1; end
      expect_v = 32'(a16) + 32'(b16) + 32'(c);
      run_add16(a16, b16, c, lat, s16, co);
      checks++;
      if (lat !== 17 || {co, s16} !== expect_v[16:0]) begin
        failures++;
        $display("[TB] FAIL rand16 #%0d: a=%h b=%h cin=%b got lat=%0d {cout,sum}=%h, required lat=17 %h",
                 n, a16, b16, c, lat, {co, s16}, expect_v[16:0]);
      end
    end
  endtask

  // Scenario sequence
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_overflow_timing();
    test_hold_between_adds();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_fsm.md
# serial_adder_fsm

Bit-serial WIDTH-bit adder that reuses a single one-bit full-adder cell, built from two half adders, over WIDTH clock cycles. It sits directly upstream of that full-adder cell: it sequences operand bits into it LSB-first and registers its carry-out as the next cycle's carry-in. It captures the serial sum bits and presents the parallel result with a one-cycle done pulse. It trades the area of a ripple-carry adder for latency.

## Interface
- WIDTH, default 8, operand and sum width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the design has one clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request an add; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; the result is valid.
- sum  output  WIDTH  registered result (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.

## Operation
- States:
  - IDLE: no add in progress.
  - RUN: adding one bit per cycle.
  - DONE: result just completed.
- Registers:
  - a_sr and b_sr: operand shift registers, WIDTH bits each.
  - carry: 1 bit.
  - s_sr: sum shift register, WIDTH bits.
  - cnt: bit counter, $clog2(WIDTH+1) bits.
  - sum and cout: output registers.
- IDLE with start=1 at an edge:
  - a_sr<=a, b_sr<=b, carry<=cin, cnt<=0.
  - Go to RUN.
- IDLE with start=0: stay in IDLE. All registers hold.
- RUN, at each edge:
  - The full-adder cell takes a_sr[0], b_sr[0] and carry.
  - Half adder 1: p=a^b, g1=a&b. Half adder 2: s=p^carry, g2=p&carry. Carry-out is g1|g2.
  - s_sr<={s, s_sr[WIDTH-1:1]}: the new bit enters at the MSB and the register shifts right.
  - a_sr and b_sr shift right by one; zero fills the MSB.
  - carry<=carry-out; cnt<=cnt+1.
- RUN, final edge (cnt==WIDTH-1 before the edge):
  - sum<={s, s_sr[WIDTH-1:1]} and cout<=carry-out.
  - Go to DONE.
- DONE: lasts exactly one cycle, then IDLE unconditionally.
- start is ignored in RUN and in DONE; it is not queued. A start held high across DONE is accepted on the first IDLE edge.
- a, b and cin may change freely after the accepting edge without affecting the add in progress.
- sum and cout change only on the final RUN edge and on reset. They hold between adds, including through later RUN cycles.
- The arithmetic equals the parallel full-adder chain bit for bit. The carry propagates LSB to MSB, and overflow appears only on cout.

## Timing
- Reset (async assert, any state): state=IDLE; busy=0, done=0, sum=0, cout=0; a_sr, b_sr, s_sr, carry and cnt are all 0.
  - Reset mid-RUN aborts the add.
  - No done pulse follows.
  - sum and cout read 0, not a partial result.
- Reset release: the first edge with rst=0 may accept start.
- Call the start-accepting edge E0:
  - busy=1 from E0 through E_WIDTH; it is high for exactly WIDTH cycles.
  - The result is loaded at E_WIDTH.
  - done=1 for the single cycle between E_WIDTH and E_WIDTH+1, with sum and cout already valid.
- Latency: WIDTH+1 cycles from E0 to done high.
- Minimum issue interval: WIDTH+2 cycles between accepted starts.
- busy and done are never high together. Both come directly from state registers (no combinational path from the inputs).

## Test plan
- Reset, WIDTH=8: assert rst mid-cycle -> all outputs 0 immediately. Then start with a=0x00, b=0x00, cin=0 -> done on the 9th edge after E0; sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; busy high for exactly 8 cycles, then done high for exactly 1 cycle.
- a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0; sum and cout hold 0x00/1 until the second add's final edge.
- Pulse start at cycles 3 and 8 of RUN with new operands, and hold start high through DONE -> the first result is unaffected. The held start is accepted on the first IDLE edge.
- Assert rst at cycle 4 of a RUN with a=0x7F, b=0x01 -> no done, sum=0, cout=0. The next add, a=0x7F, b=0x01, cin=0, gives sum=0x80, cout=0.
- Random regression, WIDTH=8 and WIDTH=16, 1000 adds each -> {cout, sum} equals a+b+cin for every add.
